axi_slice_iso: RTL and testbench

- Parametrised successor of the five-channel AXI register slice.
- Each of AW/W/AR/R/B gets an independently selectable buffer mode: bypass, spill register, or FIFO.
- Adds per-direction outstanding-transaction tracking and an isolate/drain handshake, so a subsystem can be fenced off before power-down or reset.
- Sits between an interconnect port and a peripheral/cluster AXI port.

---
 rtl/axi_slice_iso_pkg.sv | 50 +++++
 rtl/axi_chan_buf.sv | 103 ++++++++++
 rtl/axi_slice_iso.sv | 163 ++++++++++++++++
 tb/tb_axi_slice_iso.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_slice_iso_pkg.sv
// Shared constants, packed-payload widths and field order for the AXI isolating slice.
package axi_slice_iso_pkg;

  localparam int MODE_BYPASS = 0;
  localparam int MODE_SPILL  = 1;
  localparam int MODE_FIFO   = 2;

  localparam int PROT_W   = 3;
  localparam int REGION_W = 4;
  localparam int LEN_W    = 8;
  localparam int SIZE_W   = 3;
  localparam int BURST_W  = 2;
  localparam int LOCK_W   = 1;
  localparam int CACHE_W  = 4;
  localparam int QOS_W    = 4;
  localparam int RESP_W   = 2;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_ISOLATED} iso_state_e;

  // AW/AR, MSB first: addr, prot, region, len, size, burst, lock, cache, qos, id, user
  function automatic int aw_w(input int addr_w, input int id_w, input int user_w);
    return addr_w + PROT_W + REGION_W + LEN_W + SIZE_W + BURST_W + LOCK_W
           + CACHE_W + QOS_W + id_w + user_w;
  endfunction

  function automatic int ar_w(input int addr_w, input int id_w, input int user_w);
    return aw_w(addr_w, id_w, user_w);
  endfunction

  // W, MSB first: data, strb, user, last
  function automatic int w_w(input int data_w, input int user_w);
    return data_w + data_w / 8 + user_w + 1;
  endfunction

  // R, MSB first: data, resp, last, id, user
  function automatic int r_w(input int data_w, input int id_w, input int user_w);
    return data_w + RESP_W + 1 + id_w + user_w;
  endfunction

  // B, MSB first: resp, id, user
  function automatic int b_w(input int id_w, input int user_w);
    return RESP_W + id_w + user_w;
  endfunction

  // Bit position of r_last inside a packed R payload
  function automatic int r_last_idx(input int id_w, input int user_w);
    return id_w + user_w;
  endfunction

endpackage

// File: rtl/axi_chan_buf.sv
// One AXI channel buffer: combinational bypass, 2-entry spill register, or FIFO.
module axi_chan_buf
  import axi_slice_iso_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MODE  = MODE_SPILL,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             test_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             empty
);

  // Only a clock-gating hook; nothing functional depends on it
  logic unused_test_en;
  assign unused_test_en = test_en;

  if (MODE == MODE_BYPASS) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign out_valid = in_valid;
    assign out_data  = in_data;
    assign in_ready  = out_ready;
    assign empty     = 1'b1;

  end else if (MODE == MODE_SPILL) begin : g_spill
    // Stage A takes new input, stage B parks the older beat when output stalls
    logic             a_full, b_full;
    logic [WIDTH-1:0] a_data, b_data;
    logic             a_fill, a_drain, b_fill, b_drain;

    assign in_ready  = !a_full || !b_full;
    assign out_valid = a_full || b_full;
    assign out_data  = b_full ? b_data : a_data;
    assign empty     = !a_full && !b_full;

    assign a_fill  = in_valid && in_ready;
    assign a_drain = a_full && !b_full;
    assign b_fill  = a_drain && !out_ready;
    assign b_drain = b_full && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_full <= 1'b0;
        b_full <= 1'b0;
      end else begin
        if (a_fill)       a_full <= 1'b1;
        else if (a_drain) a_full <= 1'b0;
        if (b_fill)       b_full <= 1'b1;
        else if (b_drain) b_full <= 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (a_fill) a_data <= in_data;
      if (b_fill) b_data <= a_data;
    end

  end else begin : g_fifo
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FCNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]  wptr, rptr;
    logic [FCNT_W-1:0] count;
    logic              push, pop;

    assign in_ready  = (count != FCNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign out_data  = mem[rptr];
    assign empty     = (count == '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (push) wptr <= (wptr == PTR_W'(DEPTH - 1)) ? '0 : wptr + 1'b1;
        if (pop)  rptr <= (rptr == PTR_W'(DEPTH - 1)) ? '0 : rptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (push) mem[wptr] <= in_data;
    end
  end

endmodule

// File: rtl/axi_slice_iso.sv
// Five-channel AXI slice with per-channel buffering, outstanding tracking and isolate/drain.
module axi_slice_iso
  import axi_slice_iso_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int AXI_DATA_WIDTH  = 64,
  parameter int AXI_USER_WIDTH  = 6,
  parameter int AXI_ID_WIDTH    = 3,
  parameter int AW_MODE         = 1,
  parameter int W_MODE          = 1,
  parameter int AR_MODE         = 1,
  parameter int R_MODE          = 1,
  parameter int B_MODE          = 1,
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 8,
  localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
  localparam int AW_W  = aw_w(AXI_ADDR_WIDTH, AXI_ID_WIDTH, AXI_USER_WIDTH),
  localparam int W_W   = w_w(AXI_DATA_WIDTH, AXI_USER_WIDTH),
  localparam int AR_W  = ar_w(AXI_ADDR_WIDTH, AXI_ID_WIDTH, AXI_USER_WIDTH),
  localparam int R_W   = r_w(AXI_DATA_WIDTH, AXI_ID_WIDTH, AXI_USER_WIDTH),
  localparam int B_W   = b_w(AXI_ID_WIDTH, AXI_USER_WIDTH),
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            test_en_i,
  input  logic            isolate_i,
  output logic            isolated_o,
  output logic [CNT_W-1:0] wr_outstanding_o,
  output logic [CNT_W-1:0] rd_outstanding_o,
  input  logic            slave_aw_valid_i,
  output logic            slave_aw_ready_o,
  input  logic [AW_W-1:0] slave_aw_data_i,
  input  logic            slave_w_valid_i,
  output logic            slave_w_ready_o,
  input  logic [W_W-1:0]  slave_w_data_i,
  input  logic            slave_ar_valid_i,
  output logic            slave_ar_ready_o,
  input  logic [AR_W-1:0] slave_ar_data_i,
  output logic            slave_r_valid_o,
  input  logic            slave_r_ready_i,
  output logic [R_W-1:0]  slave_r_data_o,
  output logic            slave_b_valid_o,
  input  logic            slave_b_ready_i,
  output logic [B_W-1:0]  slave_b_data_o,
  output logic            master_aw_valid_o,
  input  logic            master_aw_ready_i,
  output logic [AW_W-1:0] master_aw_data_o,
  output logic            master_w_valid_o,
  input  logic            master_w_ready_i,
  output logic [W_W-1:0]  master_w_data_o,
  output logic            master_ar_valid_o,
  input  logic            master_ar_ready_i,
  output logic [AR_W-1:0] master_ar_data_o,
  input  logic            master_r_valid_i,
  output logic            master_r_ready_o,
  input  logic [R_W-1:0]  master_r_data_i,
  input  logic            master_b_valid_i,
  output logic            master_b_ready_o,
  input  logic [B_W-1:0]  master_b_data_i
);

  localparam int R_LAST = r_last_idx(AXI_ID_WIDTH, AXI_USER_WIDTH);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0] wr_cnt, rd_cnt;
  logic aw_gate, ar_gate, aw_buf_ready, ar_buf_ready;
  logic aw_empty, w_empty, ar_empty, r_empty, b_empty;
  logic wr_inc, wr_dec, rd_inc, rd_dec, quiet;
  iso_state_e state, state_next;

  // New transactions are fenced by isolation and by the outstanding limit
  assign aw_gate          = !isolate_i && (wr_cnt < MAX_CNT);
  assign ar_gate          = !isolate_i && (rd_cnt < MAX_CNT);
  assign slave_aw_ready_o = aw_buf_ready && aw_gate;
  assign slave_ar_ready_o = ar_buf_ready && ar_gate;

  axi_chan_buf #(.WIDTH(AW_W), .MODE(AW_MODE), .DEPTH(FIFO_DEPTH)) u_aw (
    .clk(clk_i), .rst_n(rst_ni), .test_en(test_en_i),
    .in_valid(slave_aw_valid_i && aw_gate), .in_ready(aw_buf_ready), .in_data(slave_aw_data_i),
    .out_valid(master_aw_valid_o), .out_ready(master_aw_ready_i), .out_data(master_aw_data_o),
    .empty(aw_empty)
  );

  axi_chan_buf #(.WIDTH(W_W), .MODE(W_MODE), .DEPTH(FIFO_DEPTH)) u_w (
    .clk(clk_i), .rst_n(rst_ni), .test_en(test_en_i),
    .in_valid(slave_w_valid_i), .in_ready(slave_w_ready_o), .in_data(slave_w_data_i),
    .out_valid(master_w_valid_o), .out_ready(master_w_ready_i), .out_data(master_w_data_o),
    .empty(w_empty)
  );

  axi_chan_buf #(.WIDTH(AR_W), .MODE(AR_MODE), .DEPTH(FIFO_DEPTH)) u_ar (
    .clk(clk_i), .rst_n(rst_ni), .test_en(test_en_i),
    .in_valid(slave_ar_valid_i && ar_gate), .in_ready(ar_buf_ready), .in_data(slave_ar_data_i),
    .out_valid(master_ar_valid_o), .out_ready(master_ar_ready_i), .out_data(master_ar_data_o),
    .empty(ar_empty)
  );

  axi_chan_buf #(.WIDTH(R_W), .MODE(R_MODE), .DEPTH(FIFO_DEPTH)) u_r (
    .clk(clk_i), .rst_n(rst_ni), .test_en(test_en_i),
    .in_valid(master_r_valid_i), .in_ready(master_r_ready_o), .in_data(master_r_data_i),
    .out_valid(slave_r_valid_o), .out_ready(slave_r_ready_i), .out_data(slave_r_data_o),
    .empty(r_empty)
  );

  axi_chan_buf #(.WIDTH(B_W), .MODE(B_MODE), .DEPTH(FIFO_DEPTH)) u_b (
    .clk(clk_i), .rst_n(rst_ni), .test_en(test_en_i),
    .in_valid(master_b_valid_i), .in_ready(master_b_ready_o), .in_data(master_b_data_i),
    .out_valid(slave_b_valid_o), .out_ready(slave_b_ready_i), .out_data(slave_b_data_o),
    .empty(b_empty)
  );

  assign wr_inc = slave_aw_valid_i && slave_aw_ready_o;
  assign wr_dec = slave_b_valid_o && slave_b_ready_i;
  assign rd_inc = slave_ar_valid_i && slave_ar_ready_o;
  assign rd_dec = slave_r_valid_o && slave_r_ready_i && slave_r_data_o[R_LAST];

  function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] cnt,
                                               input logic inc, input logic dec);
    logic [CNT_W-1:0] res;
    res = cnt;
    if (inc && !dec)                  res = cnt + 1'b1;
    else if (dec && !inc && cnt != '0) res = cnt - 1'b1;
    return res;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
      state  <= ST_RUN;
    end else begin
      wr_cnt <= cnt_step(wr_cnt, wr_inc, wr_dec);
      rd_cnt <= cnt_step(rd_cnt, rd_inc, rd_dec);
      state  <= state_next;
    end
  end

  // Quiescent: nothing owed in either direction and no beat parked anywhere
  assign quiet = (wr_cnt == '0) && (rd_cnt == '0) && aw_empty && w_empty && ar_empty
                 && r_empty && b_empty && !slave_w_valid_i;

  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:      if (isolate_i) state_next = ST_DRAIN;
      ST_DRAIN:    if (!isolate_i) state_next = ST_RUN;
                   else if (quiet) state_next = ST_ISOLATED;
      ST_ISOLATED: if (!isolate_i) state_next = ST_RUN;
      default:     state_next = ST_RUN;
    endcase
  end

  assign isolated_o       = (state == ST_ISOLATED);
  assign wr_outstanding_o = wr_cnt;
  assign rd_outstanding_o = rd_cnt;

  a_wr_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                   !(wr_dec && !wr_inc && wr_cnt == '0));
  a_rd_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                   !(rd_dec && !rd_inc && rd_cnt == '0));

endmodule

// File: tb/tb_axi_slice_iso.sv
// Directed bench for axi_slice_iso: spill/FIFO instance plus an all-bypass instance.
module tb_axi_slice_iso;

  localparam int AW_W = 70;
  localparam int W_W  = 79;
  localparam int AR_W = 70;
  localparam int R_W  = 76;
  localparam int B_W  = 11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main instance: W in FIFO mode, all others spill
  logic isolate, isolated, test_en;
  logic [3:0] wr_out, rd_out;
  logic s_aw_valid, s_aw_ready, s_w_valid, s_w_ready, s_ar_valid, s_ar_ready;
  logic s_r_valid, s_r_ready, s_b_valid, s_b_ready;
  logic m_aw_valid, m_aw_ready, m_w_valid, m_w_ready, m_ar_valid, m_ar_ready;
  logic m_r_valid, m_r_ready, m_b_valid, m_b_ready;
  logic [AW_W-1:0] s_aw_data, m_aw_data;
  logic [W_W-1:0]  s_w_data, m_w_data;
  logic [AR_W-1:0] s_ar_data, m_ar_data;
  logic [R_W-1:0]  s_r_data, m_r_data;
  logic [B_W-1:0]  s_b_data, m_b_data;

  // Bypass instance
  logic y_isolated;
  logic [3:0] y_wr_out, y_rd_out;
  logic y_s_aw_valid, y_s_aw_ready, y_s_w_valid, y_s_w_ready, y_s_ar_valid, y_s_ar_ready;
  logic y_s_r_valid, y_s_r_ready, y_s_b_valid, y_s_b_ready;
  logic y_m_aw_valid, y_m_aw_ready, y_m_w_valid, y_m_w_ready, y_m_ar_valid, y_m_ar_ready;
  logic y_m_r_valid, y_m_r_ready, y_m_b_valid, y_m_b_ready;
  logic [AW_W-1:0] y_s_aw_data, y_m_aw_data;
  logic [W_W-1:0]  y_s_w_data, y_m_w_data;
  logic [AR_W-1:0] y_s_ar_data, y_m_ar_data;
  logic [R_W-1:0]  y_s_r_data, y_m_r_data;
  logic [B_W-1:0]  y_s_b_data, y_m_b_data;

  axi_slice_iso #(.W_MODE(2)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .test_en_i(test_en), .isolate_i(isolate),
    .isolated_o(isolated), .wr_outstanding_o(wr_out), .rd_outstanding_o(rd_out),
    .slave_aw_valid_i(s_aw_valid), .slave_aw_ready_o(s_aw_ready), .slave_aw_data_i(s_aw_data),
    .slave_w_valid_i(s_w_valid), .slave_w_ready_o(s_w_ready), .slave_w_data_i(s_w_data),
    .slave_ar_valid_i(s_ar_valid), .slave_ar_ready_o(s_ar_ready), .slave_ar_data_i(s_ar_data),
    .slave_r_valid_o(s_r_valid), .slave_r_ready_i(s_r_ready), .slave_r_data_o(s_r_data),
    .slave_b_valid_o(s_b_valid), .slave_b_ready_i(s_b_ready), .slave_b_data_o(s_b_data),
    .master_aw_valid_o(m_aw_valid), .master_aw_ready_i(m_aw_ready), .master_aw_data_o(m_aw_data),
    .master_w_valid_o(m_w_valid), .master_w_ready_i(m_w_ready), .master_w_data_o(m_w_data),
    .master_ar_valid_o(m_ar_valid), .master_ar_ready_i(m_ar_ready), .master_ar_data_o(m_ar_data),
    .master_r_valid_i(m_r_valid), .master_r_ready_o(m_r_ready), .master_r_data_i(m_r_data),
    .master_b_valid_i(m_b_valid), .master_b_ready_o(m_b_ready), .master_b_data_i(m_b_data)
  );

  axi_slice_iso #(.AW_MODE(0), .W_MODE(0), .AR_MODE(0), .R_MODE(0), .B_MODE(0)) u_byp (
    .clk_i(clk), .rst_ni(rst_n), .test_en_i(test_en), .isolate_i(1'b0),
    .isolated_o(y_isolated), .wr_outstanding_o(y_wr_out), .rd_outstanding_o(y_rd_out),
    .slave_aw_valid_i(y_s_aw_valid), .slave_aw_ready_o(y_s_aw_ready), .slave_aw_data_i(y_s_aw_data),
    .slave_w_valid_i(y_s_w_valid), .slave_w_ready_o(y_s_w_ready), .slave_w_data_i(y_s_w_data),
    .slave_ar_valid_i(y_s_ar_valid), .slave_ar_ready_o(y_s_ar_ready), .slave_ar_data_i(y_s_ar_data),
    .slave_r_valid_o(y_s_r_valid), .slave_r_ready_i(y_s_r_ready), .slave_r_data_o(y_s_r_data),
    .slave_b_valid_o(y_s_b_valid), .slave_b_ready_i(y_s_b_ready), .slave_b_data_o(y_s_b_data),
    .master_aw_valid_o(y_m_aw_valid), .master_aw_ready_i(y_m_aw_ready), .master_aw_data_o(y_m_aw_data),
    .master_w_valid_o(y_m_w_valid), .master_w_ready_i(y_m_w_ready), .master_w_data_o(y_m_w_data),
    .master_ar_valid_o(y_m_ar_valid), .master_ar_ready_i(y_m_ar_ready), .master_ar_data_o(y_m_ar_data),
    .master_r_valid_i(y_m_r_valid), .master_r_ready_o(y_m_r_ready), .master_r_data_i(y_m_r_data),
    .master_b_valid_i(y_m_b_valid), .master_b_ready_o(y_m_b_ready), .master_b_data_i(y_m_b_data)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW_W-1:0] awpat(input int k);
    return {32'h1000_0000 + 32'(k), 29'(k * 3), 3'(k), 6'(k)};
  endfunction
  function automatic logic [W_W-1:0] wpat(input int k);
    return {{8{8'(k + 8'hA0)}}, 8'hFF, 6'(k), 1'(k & 1)};
  endfunction
  function automatic logic [R_W-1:0] rpat(input int k, input logic last);
    return {64'hCAFE_0000 + 64'(k), 2'b00, last, 3'(k), 6'h15};
  endfunction
  function automatic logic [B_W-1:0] bpat(input int k);
    return {2'b01, 3'(k), 6'(k + 1)};
  endfunction

  int  sent, rcv, nin, nout;
  logic s_hs, m_hs;

  initial begin
    test_en = 0; isolate = 0;
    s_aw_valid = 0; s_aw_data = '0; s_w_valid = 0; s_w_data = '0;
    s_ar_valid = 0; s_ar_data = '0; s_r_ready = 1; s_b_ready = 1;
    m_aw_ready = 1; m_w_ready = 1; m_ar_ready = 1;
    m_r_valid = 0; m_r_data = '0; m_b_valid = 0; m_b_data = '0;
    y_s_aw_valid = 0; y_s_aw_data = '0; y_s_w_valid = 0; y_s_w_data = '0;
    y_s_ar_valid = 0; y_s_ar_data = '0; y_s_r_ready = 0; y_s_b_ready = 0;
    y_m_aw_ready = 0; y_m_w_ready = 0; y_m_ar_ready = 0;
    y_m_r_valid = 0; y_m_r_data = '0; y_m_b_valid = 0; y_m_b_data = '0;

    // Reset state
    #2;
    check("rst_m_aw_valid", m_aw_valid, 0);
    check("rst_s_b_valid", s_b_valid, 0);
    check("rst_s_r_valid", s_r_valid, 0);
    check("rst_wr_cnt", wr_out, 0);
    check("rst_rd_cnt", rd_out, 0);
    check("rst_isolated", isolated, 0);
    check("rst_aw_ready", s_aw_ready, 1);
    check("rst_w_ready", s_w_ready, 1);
    tick(); tick();
    rst_n = 1;
    tick();

    // Spill throughput: 100 AW back to back, B returned one cycle after each master AW
    sent = 0; rcv = 0;
    for (int cyc = 0; cyc < 101; cyc++) begin
      s_aw_valid = (sent < 100);
      s_aw_data  = awpat(sent);
      s_hs = s_aw_valid && s_aw_ready;
      m_hs = m_aw_valid && m_aw_ready;
      if (m_hs) begin
        check("aw_order", m_aw_data, awpat(rcv));
        rcv++;
      end
      tick();
      if (s_hs) sent++;
      m_b_valid = m_hs;
      m_b_data  = bpat(cyc);
    end
    check("aw_sent", sent, 100);
    check("aw_master_hs", rcv, 100);
    s_aw_valid = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      m_b_valid = 0;
    end
    check("aw_drain_wr_cnt", wr_out, 0);

    // Fill both spill stages, then show slave ready has no path from master ready
    m_aw_ready = 0; s_aw_valid = 1; s_aw_data = awpat(200);
    tick();
    s_aw_data = awpat(201);
    tick();
    s_aw_valid = 0;
    check("spill_full_ready", s_aw_ready, 0);
    check("spill_head_data", m_aw_data, awpat(200));
    check("spill_wr_cnt", wr_out, 2);
    m_aw_ready = 1;
    #1;
    check("no_comb_ready", s_aw_ready, 0);
    tick();
    check("spill_second_data", m_aw_data, awpat(201));
    check("spill_ready_back", s_aw_ready, 1);

    // Isolate with two writes outstanding
    isolate = 1; s_aw_valid = 1; s_aw_data = awpat(202);
    #1;
    check("iso_gate_aw", s_aw_ready, 0);
    tick();
    check("iso_aw_out_empty", m_aw_valid, 0);
    m_b_valid = 1; m_b_data = bpat(0);
    tick();
    check("iso_b0_valid", s_b_valid, 1);
    check("iso_b0_data", s_b_data, bpat(0));
    check("iso_not_yet_1", isolated, 0);
    m_b_data = bpat(1);
    tick();
    check("iso_b1_data", s_b_data, bpat(1));
    check("iso_wr_cnt_1", wr_out, 1);
    m_b_valid = 0;
    tick();
    check("iso_wr_cnt_0", wr_out, 0);
    check("iso_not_yet_2", isolated, 0);
    tick();
    check("iso_done", isolated, 1);
    check("iso_aw_still_gated", s_aw_ready, 0);

    // Leave isolation, then abort a drain
    isolate = 0;
    #1;
    check("unisolate_ready", s_aw_ready, 1);
    tick();
    check("unisolate_wr_cnt", wr_out, 1);
    check("unisolate_flag", isolated, 0);
    s_aw_data = awpat(203); isolate = 1;
    tick(); tick();
    check("drain_flag", isolated, 0);
    check("drain_aw_gated", s_aw_ready, 0);
    check("drain_wr_cnt", wr_out, 1);
    isolate = 0;
    tick();
    check("abort_aw_accepted", wr_out, 2);
    s_aw_valid = 0;

    // W FIFO backpressure: 6 beats, master stalled, then released
    m_w_ready = 0; nin = 0; nout = 0;
    for (int c = 0; c < 6; c++) begin
      s_w_valid = (nin < 6);
      s_w_data  = wpat(nin);
      check("w_ready_fill", s_w_ready, (c < 4) ? 1 : 0);
      s_hs = s_w_valid && s_w_ready;
      tick();
      if (s_hs) nin++;
    end
    check("w_accepted_stall", nin, 4);
    m_w_ready = 1;
    for (int c = 0; c < 10; c++) begin
      s_w_valid = (nin < 6);
      s_w_data  = wpat(nin);
      s_hs = s_w_valid && s_w_ready;
      m_hs = m_w_valid && m_w_ready;
      if (m_hs) begin
        check("w_order", m_w_data, wpat(nout));
        nout++;
      end
      tick();
      if (s_hs) nin++;
    end
    s_w_valid = 0;
    check("w_in_total", nin, 6);
    check("w_out_total", nout, 6);

    // Read outstanding limit
    for (int k = 0; k < 8; k++) begin
      s_ar_valid = 1; s_ar_data = awpat(300 + k);
      check("ar_ready_below_limit", s_ar_ready, 1);
      tick();
    end
    s_ar_data = awpat(308);
    check("ar_limit_cnt", rd_out, 8);
    check("ar_limit_ready", s_ar_ready, 0);
    m_r_valid = 1; m_r_data = rpat(0, 1'b0);
    tick();
    check("r0_valid", s_r_valid, 1);
    check("r0_data", s_r_data, rpat(0, 1'b0));
    m_r_data = rpat(1, 1'b1);
    tick();
    check("r1_data", s_r_data, rpat(1, 1'b1));
    check("r_nonlast_no_dec", rd_out, 8);
    check("ar_still_stalled", s_ar_ready, 0);
    m_r_valid = 0;
    tick();
    check("r_last_dec", rd_out, 7);
    check("ar_ready_reopen", s_ar_ready, 1);
    tick();
    check("ar_ninth_accepted", rd_out, 8);
    s_ar_valid = 0;

    // Asynchronous reset with three W beats parked in the FIFO
    m_w_ready = 0;
    for (int k = 0; k < 3; k++) begin
      s_w_valid = 1; s_w_data = wpat(10 + k);
      tick();
    end
    s_w_valid = 0;
    tick();
    check("pre_rst_w_valid", m_w_valid, 1);
    check("pre_rst_w_ready", s_w_ready, 1);
    check("pre_rst_wr_cnt", wr_out, 2);
    check("pre_rst_rd_cnt", rd_out, 8);
    #2;
    rst_n = 0;
    #1;
    check("async_rst_w_valid", m_w_valid, 0);
    check("async_rst_aw_valid", m_aw_valid, 0);
    check("async_rst_ar_valid", m_ar_valid, 0);
    check("async_rst_r_valid", s_r_valid, 0);
    check("async_rst_b_valid", s_b_valid, 0);
    check("async_rst_wr_cnt", wr_out, 0);
    check("async_rst_rd_cnt", rd_out, 0);
    check("async_rst_isolated", isolated, 0);
    tick();
    rst_n = 1;
    m_w_ready = 1;
    tick();
    check("post_rst_w_valid", m_w_valid, 0);

    // Bypass instance: zero-latency combinational pass-through
    y_s_aw_valid = 1; y_s_aw_data = awpat(7); y_m_aw_ready = 1;
    #1;
    check("byp_aw_valid", y_m_aw_valid, 1);
    check("byp_aw_data", y_m_aw_data, awpat(7));
    check("byp_aw_ready", y_s_aw_ready, 1);
    y_m_aw_ready = 0;
    #1;
    check("byp_aw_ready_low", y_s_aw_ready, 0);
    y_s_aw_valid = 0;
    y_s_w_valid = 1; y_s_w_data = wpat(3); y_m_w_ready = 1;
    y_m_r_valid = 1; y_m_r_data = rpat(5, 1'b0); y_s_r_ready = 1;
    y_m_b_valid = 1; y_m_b_data = bpat(2); y_s_b_ready = 0;
    #1;
    check("byp_w_data", y_m_w_data, wpat(3));
    check("byp_w_ready", y_s_w_ready, 1);
    check("byp_r_valid", y_s_r_valid, 1);
    check("byp_r_data", y_s_r_data, rpat(5, 1'b0));
    check("byp_r_ready", y_m_r_ready, 1);
    check("byp_b_data", y_s_b_data, bpat(2));
    check("byp_b_ready", y_m_b_ready, 0);
    y_s_w_valid = 0; y_m_r_valid = 0; y_m_b_valid = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
